sram_to_sram_like_bridge: RTL and testbench

- Parametrised SRAM-to-SRAM-like converter for the instruction and data ports of the CPU core.
- Stalls the pipeline while a transaction is outstanding and returns read data from a holding register.
- Keeps the completed state until the global longest_stall releases.
- Adds write support with byte-enable to size/offset mapping, an instruction-only mode, and a watchdog timeout flag.

---
 rtl/cpu_axi_pkg.sv | 14 +
 rtl/be_to_size.sv | 29 ++
 rtl/sram_to_sram_like_bridge.sv | 102 ++++++++++
 tb/tb_sram_to_sram_like_bridge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared size codes and bridge state encoding
package cpu_axi_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/be_to_size.sv
// rtl/be_to_size.sv - byte-enable to {size, low address bits, illegal} decoder
module be_to_size
    import cpu_axi_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size,
    output logic [1:0] lo,
    output logic       illegal
);

    // An all-zero enable is a read and maps to an aligned word access.
    always_comb begin
        size    = SIZE_W;
        lo      = 2'd0;
        illegal = 1'b0;
        case (wen)
            4'b0000: ;
            4'b0001: begin size = SIZE_B; lo = 2'd0; end
            4'b0010: begin size = SIZE_B; lo = 2'd1; end
            4'b0100: begin size = SIZE_B; lo = 2'd2; end
            4'b1000: begin size = SIZE_B; lo = 2'd3; end
            4'b0011: begin size = SIZE_H; lo = 2'd0; end
            4'b1100: begin size = SIZE_H; lo = 2'd2; end
            4'b1111: ;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sram_to_sram_like_bridge.sv
// rtl/sram_to_sram_like_bridge.sv - SRAM pipeline port to SRAM-like bus converter
module sram_to_sram_like_bridge
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WRITE_EN = 1,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sram_en,
    input  logic [DATA_W/8-1:0] sram_wen,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W-1:0]   sram_rdata,
    output logic                stall,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                longest_stall,
    output logic                size_err,
    output logic                timeout_err
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("sram_to_sram_like_bridge: only DATA_W = 32 is supported");
    end
    if ((TIMEOUT != 0) && ((64'd1 << CNT_W) <= 64'(TIMEOUT))) begin : g_bad_cnt_w
        $error("sram_to_sram_like_bridge: CNT_W too narrow for TIMEOUT");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bridge_state_e    state, state_n;
    logic             req_i, accept, counting, illegal, wr_q;
    logic [3:0]       be;
    logic [1:0]       lo;
    logic [CNT_W-1:0] cnt;
    logic             unused_addr_lo;

    assign be             = (WRITE_EN != 0) ? sram_wen : 4'b0000;
    assign wr             = |be;
    assign wdata          = (WRITE_EN != 0) ? sram_wdata : '0;
    assign addr           = {sram_addr[ADDR_W-1:2], lo};
    assign unused_addr_lo = ^sram_addr[1:0];

    be_to_size u_be_to_size (
        .wen     (be),
        .size    (size),
        .lo      (lo),
        .illegal (illegal)
    );

    always_comb begin
        state_n = state;
        req_i   = 1'b0;
        case (state)
            IDLE: begin
                req_i = sram_en;
                if (req_i && addr_ok) state_n = data_ok ? DONE : WAIT;
            end
            WAIT:    if (data_ok) state_n = DONE;
            DONE:    if (!longest_stall) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Gating with rst makes the handshake outputs drop at once on an async reset.
    assign accept   = req_i & addr_ok;
    assign counting = req_i | (state == WAIT);
    assign req      = req_i & ~rst;
    assign stall    = sram_en & (state != DONE) & ~rst;
    assign size_err = accept & wr & illegal & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            sram_rdata  <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) wr_q <= wr;
            // The direction is latched at accept because sram_wen may change once sram_en drops in WAIT.
            if ((accept && data_ok && !wr) || (state == WAIT && data_ok && !wr_q))
                sram_rdata <= rdata;
            if (!counting)          cnt <= '0;
            else if (cnt != '1)     cnt <= cnt + 1'b1;
            if ((TIMEOUT != 0) && counting && (cnt == CNT_LAST) && !data_ok)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_to_sram_like_bridge.sv
// tb/tb_sram_to_sram_like_bridge.sv - directed self-checking bench for the bridge
module tb_sram_to_sram_like_bridge;
    import cpu_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, addr_ok = 1'b0, data_ok = 1'b0, ls = 1'b0;
    logic [3:0]  wen = 4'b0;
    logic [31:0] saddr = '0, swdata = '0, rdata = '0;
    logic [31:0] sram_rdata, addr, wdata;
    logic        stall, req, wr, size_err, timeout_err;
    logic [1:0]  size;

    int n_chk  = 0;
    int n_fail = 0;

    sram_to_sram_like_bridge #(
        .ADDR_W(32), .DATA_W(32), .WRITE_EN(1), .TIMEOUT(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .sram_en(en), .sram_wen(wen), .sram_addr(saddr), .sram_wdata(swdata),
        .sram_rdata(sram_rdata), .stall(stall),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .longest_stall(ls), .size_err(size_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, with sram_en already high
        en = 1'b1;
        #2;
        chk("rst_rdata", sram_rdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_size_err", 32'(size_err), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        en = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // read completing in the accept cycle
        en = 1'b1; wen = 4'b0000; saddr = 32'h1000_0006;
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
        #1;
        chk("rd1_req", 32'(req), 32'd1);
        chk("rd1_stall", 32'(stall), 32'd1);
        chk("rd1_addr", addr, 32'h1000_0004);
        chk("rd1_size", 32'(size), 32'(SIZE_W));
        chk("rd1_wr", 32'(wr), 32'd0);
        step();
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'hDEAD_0000;
        #1;
        chk("rd1_rdata", sram_rdata, 32'h1234_5678);
        chk("rd1_done_stall", 32'(stall), 32'd0);
        chk("rd1_done_req", 32'(req), 32'd0);
        step();
        en = 1'b0;
        #1;
        chk("rd1_idle_req", 32'(req), 32'd0);

        // byte write then upper-half write
        en = 1'b1; wen = 4'b0100; saddr = 32'h8000_0011; swdata = 32'hAABB_CCDD;
        addr_ok = 1'b1; data_ok = 1'b1;
        #1;
        chk("wb_size", 32'(size), 32'(SIZE_B));
        chk("wb_addr", addr, 32'h8000_0012);
        chk("wb_wr", 32'(wr), 32'd1);
        chk("wb_wdata", wdata, 32'hAABB_CCDD);
        chk("wb_size_err", 32'(size_err), 32'd0);
        step();
        addr_ok = 1'b0; data_ok = 1'b0; en = 1'b0;
        #1;
        chk("wb_rdata_kept", sram_rdata, 32'h1234_5678);
        step();
        en = 1'b1; wen = 4'b1100; saddr = 32'h8000_0020;
        addr_ok = 1'b1; data_ok = 1'b1;
        #1;
        chk("wh_size", 32'(size), 32'(SIZE_H));
        chk("wh_addr", addr, 32'h8000_0022);
        step();
        addr_ok = 1'b0; data_ok = 1'b0; en = 1'b0; wen = 4'b0000;
        step();

        // read with data_ok three cycles after accept, held in DONE by longest_stall
        en = 1'b1; saddr = 32'h0000_0100; addr_ok = 1'b1; ls = 1'b1;
        #1;
        chk("rd3_req_c0", 32'(req), 32'd1);
        step();
        addr_ok = 1'b0;
        #1;
        chk("rd3_req_c1", 32'(req), 32'd0);
        chk("rd3_stall_c1", 32'(stall), 32'd1);
        step();
        #1;
        chk("rd3_req_c2", 32'(req), 32'd0);
        step();
        data_ok = 1'b1; rdata = 32'hCAFE_F00D;
        #1;
        chk("rd3_stall_c3", 32'(stall), 32'd1);
        chk("rd3_rdata_old", sram_rdata, 32'h1234_5678);
        step();
        data_ok = 1'b0;
        #1;
        chk("rd3_rdata", sram_rdata, 32'hCAFE_F00D);
        chk("rd3_done_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("rd3_hold_req", 32'(req), 32'd0);
            step();
        end
        ls = 1'b0;
        #1;
        chk("rd3_last_done_req", 32'(req), 32'd0);
        step();
        chk("rd3_back_idle_req", 32'(req), 32'd1);
        en = 1'b0;
        step();

        // sram_en dropped while waiting for data
        en = 1'b1; saddr = 32'h0000_0200; addr_ok = 1'b1;
        step();
        en = 1'b0; addr_ok = 1'b0;
        #1;
        chk("drop_stall", 32'(stall), 32'd0);
        chk("drop_req", 32'(req), 32'd0);
        step();
        data_ok = 1'b1; rdata = 32'h0BAD_BEEF;
        step();
        data_ok = 1'b0;
        #1;
        chk("drop_rdata", sram_rdata, 32'h0BAD_BEEF);
        step();

        // illegal byte-enable pattern
        en = 1'b1; wen = 4'b0101; saddr = 32'h4000_0003;
        #1;
        chk("ill_size", 32'(size), 32'(SIZE_W));
        chk("ill_addr", addr, 32'h4000_0000);
        chk("ill_pre_err", 32'(size_err), 32'd0);
        step();
        addr_ok = 1'b1;
        #1;
        chk("ill_err_pulse", 32'(size_err), 32'd1);
        step();
        addr_ok = 1'b0;
        #1;
        chk("ill_err_gone", 32'(size_err), 32'd0);
        data_ok = 1'b1; rdata = 32'h7777_7777;
        step();
        data_ok = 1'b0; en = 1'b0; wen = 4'b0000;
        #1;
        chk("ill_no_capture", sram_rdata, 32'h0BAD_BEEF);
        step();

        // flush: request withdrawn before addr_ok must not start a transaction
        en = 1'b1; saddr = 32'h0000_0300;
        step();
        en = 1'b0; addr_ok = 1'b1;
        #1;
        chk("flush_req", 32'(req), 32'd0);
        step();
        en = 1'b1; addr_ok = 1'b0;
        #1;
        chk("flush_still_idle", 32'(req), 32'd1);

        // watchdog: accept now, data_ok never arrives
        addr_ok = 1'b1;
        #1;
        chk("wd_c0", 32'(timeout_err), 32'd0);
        step();
        addr_ok = 1'b0;
        for (int i = 1; i < 8; i++) begin
            chk("wd_early", 32'(timeout_err), 32'd0);
            step();
        end
        chk("wd_set", 32'(timeout_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_sticky", 32'(timeout_err), 32'd1);
        end

        // async reset between edges while in WAIT
        #2;
        chk("arst_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_rdata", sram_rdata, 32'h0);
        chk("arst_timeout", 32'(timeout_err), 32'd0);
        step(); step();
        rst = 1'b0;
        saddr = 32'h0000_0400; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h55AA_33CC;
        #1;
        chk("post_rst_req", 32'(req), 32'd1);
        step();
        addr_ok = 1'b0; data_ok = 1'b0; en = 1'b0;
        #1;
        chk("post_rst_rdata", sram_rdata, 32'h55AA_33CC);
        chk("post_rst_timeout", 32'(timeout_err), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
